// File: rtl/deserializer_n.sv
// deserializer_n: serial-to-parallel receiver for the 100 kHz domain.
// Shifts in WIDTH bits strobed by write_in and presents the assembled word
// to the downstream queue with a data_ready/ack_in handshake.
//
// Handshake: data_ready rises on the edge that accepts the final bit of a
// frame and stays high, with data_out and parity_err frozen, until ack_in is
// sampled high. The ack edge clears the word and the block re-arms one cycle
// later. status_out is high exactly while bits are being accepted.
//
// Optional feature: define DESER_PARITY_EN to append one parity bit to every
// frame and drive parity_err; without it parity_err is tied low and the port
// list is unchanged.
//
// The FSM state is held in state_q (type state_t) for checkers to bind to.
module deserializer_n #(
  parameter int WIDTH       = 8,
  parameter int MSB_FIRST   = 1,
  parameter int TIMEOUT_CYC = 0,
  parameter int PARITY_ODD  = 0
) (
  input  logic                       clock_100KHZ,
  input  logic                       reset,
  input  logic                       data_in,
  input  logic                       write_in,
  input  logic                       ack_in,
  output logic                       status_out,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_ready,
  output logic [$clog2(WIDTH+2)-1:0] bit_count,
  output logic                       timeout_err,
  output logic                       parity_err
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam int IW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

`ifdef DESER_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif

  typedef enum logic [1:0] {
    ST_START   = 2'd0,
    ST_RECEIVE = 2'd1,
`ifdef DESER_PARITY_EN
    ST_PARITY  = 2'd2,
`endif
    ST_WAIT    = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    count_q;
  logic [IW-1:0]    idle_q;
  logic             timeout_q;
  logic             active;
  logic             last_data;
  logic             timeout_hit;

  // Receiving window (data or parity bit) and the frame-complete / stale-word decisions.
  always_comb begin
    active = (state_q == ST_RECEIVE);
`ifdef DESER_PARITY_EN
    if (state_q == ST_PARITY) active = 1'b1;
`endif
    last_data   = (state_q == ST_RECEIVE) && write_in && (count_q == CW'(WIDTH - 1));
    timeout_hit = (TIMEOUT_CYC > 0) && active && (count_q != '0) && !write_in &&
                  (int'(idle_q) == TIMEOUT_CYC - 1);
  end

  // State register; asynchronous reset drops any frame in progress.
  always_ff @(posedge clock_100KHZ or posedge reset) begin
    if (reset) state_q <= ST_START;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_START:   state_d = ST_RECEIVE;
      ST_RECEIVE: begin
        if (last_data) begin
`ifdef DESER_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_WAIT;
`endif
        end
      end
`ifdef DESER_PARITY_EN
      ST_PARITY: begin
        if (timeout_hit)   state_d = ST_RECEIVE;
        else if (write_in) state_d = ST_WAIT;
      end
`endif
      ST_WAIT:    if (ack_in) state_d = ST_START;
      default:    state_d = ST_START;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    status_out = active;
    data_ready = (state_q == ST_WAIT);
  end

  // Datapath: shift register, bit counter, idle counter and error flags.
  always_ff @(posedge clock_100KHZ or posedge reset) begin
    if (reset) begin
      data_q    <= '0;
      count_q   <= '0;
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (timeout_hit) begin
        // Stale partial word: discard and start counting a fresh frame.
        data_q    <= '0;
        count_q   <= '0;
        idle_q    <= '0;
        timeout_q <= 1'b1;
      end else if (active && write_in) begin
        idle_q <= '0;
        if (count_q != CW'(FRAME_BITS)) count_q <= count_q + 1'b1;
        if (state_q == ST_RECEIVE) begin
          if (MSB_FIRST != 0) data_q <= {data_q[WIDTH-2:0], data_in};
          else                data_q <= {data_in, data_q[WIDTH-1:1]};
        end
      end else if (active && (count_q != '0) && (TIMEOUT_CYC > 0)) begin
        idle_q <= idle_q + 1'b1;
      end else if (!active) begin
        idle_q <= '0;
      end

      if ((state_q == ST_WAIT) && ack_in) begin
        data_q  <= '0;
        count_q <= '0;
      end
    end
  end

`ifdef DESER_PARITY_EN
  logic parity_q;
  logic parity_sense;

  assign parity_sense = (PARITY_ODD != 0);

  // Parity flag: computed when the parity bit is accepted, held through WAIT.
  always_ff @(posedge clock_100KHZ or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if ((state_q == ST_PARITY) && write_in && !timeout_hit) begin
      parity_q <= ((^data_q) ^ data_in) != parity_sense;
    end else if ((state_q == ST_WAIT) && ack_in) begin
      parity_q <= 1'b0;
    end
  end

  assign parity_err = parity_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out    = data_q;
  assign bit_count   = count_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_deserializer_n.sv
// tb_deserializer_n: table-driven bench for deserializer_n (WIDTH=8).
// Two instances share all inputs: one MSB-first, one LSB-first, both with
// TIMEOUT_CYC=4. Honours DESER_PARITY_EN to send and check the parity bit.
`timescale 1us/1ns
module tb_deserializer_n;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 2);
`ifdef DESER_PARITY_EN
  localparam int FRAME_BITS = W + 1;
`else
  localparam int FRAME_BITS = W;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic data_in = 1'b0;
  logic write_in = 1'b0;
  logic ack_in = 1'b0;

  logic          m_status, m_ready, m_tout, m_perr;
  logic [W-1:0]  m_data;
  logic [CW-1:0] m_count;
  logic          l_status, l_ready, l_tout, l_perr;
  logic [W-1:0]  l_data;
  logic [CW-1:0] l_count;

  int n_pass = 0;
  int n_total = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_lsb_q[$];
  logic         exp_perr_q[$];

  typedef struct {
    logic [W-1:0] seq;
    logic [W-1:0] exp_lsb;
    logic         par;
    logic         exp_perr;
  } vec_t;

  vec_t vecs[7];

  deserializer_n #(.WIDTH(W), .MSB_FIRST(1), .TIMEOUT_CYC(4), .PARITY_ODD(0)) dut_m (
    .clock_100KHZ(clk), .reset(reset), .data_in(data_in), .write_in(write_in),
    .ack_in(ack_in), .status_out(m_status), .data_out(m_data), .data_ready(m_ready),
    .bit_count(m_count), .timeout_err(m_tout), .parity_err(m_perr)
  );

  deserializer_n #(.WIDTH(W), .MSB_FIRST(0), .TIMEOUT_CYC(4), .PARITY_ODD(0)) dut_l (
    .clock_100KHZ(clk), .reset(reset), .data_in(data_in), .write_in(write_in),
    .ack_in(ack_in), .status_out(l_status), .data_out(l_data), .data_ready(l_ready),
    .bit_count(l_count), .timeout_err(l_tout), .parity_err(l_perr)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] reverse(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_m_status"}, m_status, 0);
    check({tag, "_m_ready"},  m_ready, 0);
    check({tag, "_m_data"},   m_data, 0);
    check({tag, "_m_count"},  m_count, 0);
    check({tag, "_m_tout"},   m_tout, 0);
    check({tag, "_m_perr"},   m_perr, 0);
    check({tag, "_l_data"},   l_data, 0);
    check({tag, "_l_count"},  l_count, 0);
  endtask

  // Driver tasks
  task automatic wait_status();
    int t = 0;
    while (!m_status && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("status_wait", m_status, 1);
  endtask

  task automatic push_expected(input logic [W-1:0] msb, input logic [W-1:0] lsb, input logic perr);
    exp_q.push_back(msb);
    exp_lsb_q.push_back(lsb);
`ifdef DESER_PARITY_EN
    exp_perr_q.push_back(perr);
`else
    exp_perr_q.push_back(1'b0);
`endif
  endtask

  task automatic send_bits(input logic [W-1:0] seq, input int nbits, input int gap);
    for (int i = W - 1; i >= W - nbits; i--) begin
      data_in  = seq[i];
      write_in = 1'b1;
      @(negedge clk);
      if (gap > 0 && i > W - nbits) begin
        write_in = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    write_in = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] seq, input logic par, input int gap);
    send_bits(seq, W, gap);
`ifdef DESER_PARITY_EN
    data_in  = par;
    write_in = 1'b1;
    @(negedge clk);
    write_in = 1'b0;
`endif
    data_in = 1'b0;
    check("latency_ready", m_ready, 1);
  endtask

  // Scoreboard: pop the expected word once the DUT presents one.
  task automatic collect();
    int t = 0;
    logic [W-1:0] e_m, e_l;
    logic e_p;
    while (!m_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", m_ready, 1);
    if (exp_q.size() == 0) begin
      check("queue_nonempty", 0, 1);
    end else begin
      e_m = exp_q.pop_front();
      e_l = exp_lsb_q.pop_front();
      e_p = exp_perr_q.pop_front();
      check("data_msb", m_data, e_m);
      check("data_lsb", l_data, e_l);
      check("l_ready", l_ready, 1);
      check("count_full", m_count, FRAME_BITS);
      check("status_low", m_status, 0);
      check("parity_err", m_perr, e_p);
      check("l_parity_err", l_perr, e_p);
    end
  endtask

  task automatic do_ack(input logic with_write);
    ack_in   = 1'b1;
    write_in = with_write;
    data_in  = with_write;
    @(negedge clk);
    ack_in   = 1'b0;
    write_in = 1'b0;
    data_in  = 1'b0;
    check("ack_ready", m_ready, 0);
    check("ack_data", m_data, 0);
    check("ack_count", m_count, 0);
    check("ack_perr", m_perr, 0);
    check("ack_status", m_status, 0);
    @(negedge clk);
    check("rearm_status", m_status, 1);
    check("rearm_count", m_count, 0);
  endtask

  initial begin
    logic tout_seen;
    logic [W-1:0] rw;
    logic rp;
    int rg;

    vecs[0] = '{seq: 8'hB2, exp_lsb: 8'h4D, par: 1'b0, exp_perr: 1'b0};
    vecs[1] = '{seq: 8'hB2, exp_lsb: 8'h4D, par: 1'b1, exp_perr: 1'b1};
    vecs[2] = '{seq: 8'h3C, exp_lsb: 8'h3C, par: 1'b0, exp_perr: 1'b0};
    vecs[3] = '{seq: 8'h01, exp_lsb: 8'h80, par: 1'b1, exp_perr: 1'b0};
    vecs[4] = '{seq: 8'hFF, exp_lsb: 8'hFF, par: 1'b1, exp_perr: 1'b1};
    vecs[5] = '{seq: 8'h96, exp_lsb: 8'h69, par: 1'b1, exp_perr: 1'b1};
    vecs[6] = '{seq: 8'hE0, exp_lsb: 8'h07, par: 1'b0, exp_perr: 1'b1};

    // Reset state, then status rises on the first edge after release.
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check("status_rise", m_status, 1);
    check("l_status_rise", l_status, 1);

    // An empty frame never times out.
    tout_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      tout_seen = tout_seen | m_tout | l_tout;
    end
    check("no_timeout_empty", tout_seen, 0);

    // Table-driven frames, back-to-back bits.
    for (int i = 0; i < 7; i++) begin
      wait_status();
      push_expected(vecs[i].seq, vecs[i].exp_lsb, vecs[i].exp_perr);
      send_frame(vecs[i].seq, vecs[i].par, 0);
      collect();
      do_ack(1'b0);
    end

    // Random frames with inter-bit gaps below the timeout.
    for (int i = 0; i < 4; i++) begin
      rw = W'($urandom_range(0, 255));
      rp = 1'($urandom_range(0, 1));
      rg = $urandom_range(0, 3);
      wait_status();
      push_expected(rw, reverse(rw), ((^rw) ^ rp) != 1'b0);
      send_frame(rw, rp, rg);
      collect();
      do_ack(1'b0);
    end

    // Timeout: 3 bits then 4 idle cycles discards the partial word.
    wait_status();
    send_bits(8'hA0, 3, 0);
    repeat (3) @(negedge clk);
    check("pre_timeout_err", m_tout, 0);
    check("pre_timeout_count", m_count, 3);
    @(negedge clk);
    check("timeout_pulse_m", m_tout, 1);
    check("timeout_pulse_l", l_tout, 1);
    check("timeout_count", m_count, 0);
    check("timeout_data", m_data, 0);
    check("timeout_status", m_status, 1);
    @(negedge clk);
    check("timeout_single", m_tout, 0);
    push_expected(8'h5A, 8'h5A, 1'b0);
    send_frame(8'h5A, 1'b0, 0);
    collect();
    do_ack(1'b0);

    // WAIT holds the word while write_in toggles; ack with write_in drops the bit.
    wait_status();
    push_expected(8'h96, 8'h69, 1'b0);
    send_frame(8'h96, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      write_in = ~write_in;
      data_in  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    write_in = 1'b0;
    check("hold_data", m_data, 8'h96);
    check("hold_count", m_count, FRAME_BITS);
    collect();
    do_ack(1'b1);

    // Reset mid-frame clears everything asynchronously.
    wait_status();
    send_bits(8'hFF, 5, 0);
    #2 reset = 1'b1;
    #1 check_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    wait_status();
    push_expected(8'h3C, 8'h3C, 1'b0);
    send_frame(8'h3C, 1'b0, 0);
    collect();
    do_ack(1'b0);

    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
